// File: rtl/mips_pkg.sv
// Shared CPU package: ALU and multiply/divide operation encodings, the
// multiply/divide sequencer states, and the conditional-negate helpers.
package mips_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_t;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   function automatic logic is_signed_op(input md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic is_div_op(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic [MD_WIDTH-1:0] cond_neg(input logic [MD_WIDTH-1:0] x,
                                                    input logic en);
      return en ? -x : x;
   endfunction

   function automatic logic [2*MD_WIDTH-1:0] cond_neg_dw(input logic [2*MD_WIDTH-1:0] x,
                                                         input logic en);
      return en ? -x : x;
   endfunction

endpackage

// File: rtl/mips_mult_div.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle on unsigned magnitudes, sign fix at the end.
module mips_mult_div
   import mips_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   md_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   md_op_t             op_q, op_d;

   logic               sgn_op;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_part, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next;

   assign sgn_op = is_signed_op(op);
   assign mag_a  = cond_neg(a, sgn_op & a[WIDTH-1]);
   assign mag_b  = cond_neg(b, sgn_op & b[WIDTH-1]);

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}, shifted left; a borrow restores.
   assign div_part = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff = div_part - {1'b0, opnd_q};
   assign div_next = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case leaves
      // a variable unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      op_d      = op_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = op;
               neg_d     = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               rem_neg_d = sgn_op & a[WIDTH-1];
               acc_d     = is_div_op(op) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
               opnd_d    = is_div_op(op) ? mag_b : mag_a;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end else begin
               if (hi_wr) hi_d = wr_data;
               if (lo_wr) lo_d = wr_data;
            end
         end

         RUN: begin
            acc_d = is_div_op(op_q) ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
         end

         FIX: begin
            if (is_div_op(op_q)) begin
               // Divide by zero leaves |a| in the remainder, so the dividend-sign
               // fix restores a exactly; only the quotient needs overriding.
               hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], rem_neg_q);
               lo_d = (opnd_q == '0) ? '1 : cond_neg(acc_q[WIDTH-1:0], neg_q);
            end else begin
               {hi_d, lo_d} = cond_neg_dw(acc_q, neg_q);
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         op_q      <= MD_MULT;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         op_q      <= op_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mult_div.sv
// Self-checking bench for mips_mult_div: directed cases with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mips_mult_div;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   md_op_t      op;
   logic [31:0] a, b;
   logic        hi_wr, lo_wr;
   logic [31:0] wr_data;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   mips_mult_div #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result {HI,LO} of one operation, straight from the ISA rules.
   function automatic logic [63:0] md_ref(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, sq, sr;
      logic [63:0] ux, uy, uq, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (o)
         MD_MULT:  return 64'(sx * sy);
         MD_MULTU: return ux * uy;
         MD_DIV: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            sq = sx / sy;
            sr = sx % sy;
            return {sr[31:0], sq[31:0]};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            uq = ux / uy;
            ur = ux % uy;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   // Behavioural model: an accepted op finishes 33 edges later with md_ref's result.
   logic        m_busy, m_done;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   int          m_cnt;

   always @(posedge clk) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               {m_hi, m_lo} <= m_pend;
               m_done       <= 1'b1;
               m_busy       <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
         end else if (start) begin
            m_pend <= md_ref(op, a, b);
            m_busy <= 1'b1;
            m_cnt  <= 33;
         end else begin
            if (hi_wr) m_hi <= wr_data;
            if (lo_wr) m_lo <= wr_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", 64'(busy), 64'(m_busy));
         check("cyc_done", 64'(done), 64'(m_done));
         check("cyc_hi",   64'(hi),   64'(m_hi));
         check("cyc_lo",   64'(lo),   64'(m_lo));
      end
   end

   // Returns at the negedge after the start edge E0.
   task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y, input bit now);
      if (!now) @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // k counts negedges since start was driven; done at E33 is seen at k=34.
   task automatic wait_done(output int k);
      k = 1;
      while (!done && k < 45) begin
         @(negedge clk);
         k++;
      end
      if (!done) check("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic run_lit(input string name, input md_op_t o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
      int k;
      issue(o, x, y, 1'b0);
      wait_done(k);
      check({name, "_lat"}, 64'(k), 64'd34);
      check({name, "_hi"}, 64'(hi), 64'(eh));
      check({name, "_lo"}, 64'(lo), 64'(el));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int k, seen;
      reset = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0;
      hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi",   64'(hi),   64'd0);
      check("rst_lo",   64'(lo),   64'd0);
      reset  = 1'b1;
      chk_en = 1'b1;

      run_lit("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_lit("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_lit("mult_pos",  MD_MULT,  32'd2,         32'd3,         32'h0,         32'd6);
      run_lit("divu",      MD_DIVU,  32'd10,        32'd3,         32'd1,         32'd3);
      run_lit("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_lit("div_zero",  MD_DIV,   32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF);
      run_lit("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

      // start and MTHI during a running op are both ignored
      issue(MD_MULTU, 32'd2, 32'd3, 1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd5; hi_wr = 1'b1; wr_data = 32'hAA;
      @(negedge clk);
      start = 1'b0; hi_wr = 1'b0;
      wait_done(k);
      check("busy_start_hi", 64'(hi), 64'h0);
      check("busy_start_lo", 64'(lo), 64'd6);
      @(negedge clk);
      check("busy_start_idle", 64'(busy), 64'd0);

      hi_wr = 1'b1; wr_data = 32'hAA;
      @(negedge clk);
      hi_wr = 1'b0;
      check("mthi_idle", 64'(hi), 64'hAA);

      start = 1'b1; op = MD_DIVU; a = 32'd10; b = 32'd3; lo_wr = 1'b1; wr_data = 32'h55;
      @(negedge clk);
      start = 1'b0; lo_wr = 1'b0;
      check("start_lo_wr_dropped", 64'(lo), 64'd6);
      wait_done(k);
      check("start_lo_wr_lo", 64'(lo), 64'd3);
      check("start_lo_wr_hi", 64'(hi), 64'd1);

      // reset mid-operation aborts with no done pulse
      issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi",   64'(hi),   64'd0);
      check("abort_lo",   64'(lo),   64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      run_lit("post_abort", MD_DIVU, 32'd10, 32'd3, 32'd1, 32'd3);

      // randomized traffic, compared cycle by cycle against the model
      for (int n = 0; n < 150; n++) begin
         issue(md_op_t'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 30)) @(negedge clk);
         start = 1'($urandom_range(0, 1)); hi_wr = 1'($urandom_range(0, 1));
         lo_wr = 1'($urandom_range(0, 1)); wr_data = $urandom;
         op = md_op_t'($urandom_range(0, 3)); a = $urandom; b = $urandom;
         @(negedge clk);
         start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
         wait_done(k);
         repeat ($urandom_range(0, 2)) begin
            hi_wr = 1'($urandom_range(0, 1)); lo_wr = 1'($urandom_range(0, 1));
            wr_data = $urandom;
            @(negedge clk);
            hi_wr = 1'b0; lo_wr = 1'b0;
         end
      end

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
